cva6_icache_refill_assembler: RTL and testbench
===============================================

CVA6_ICACHE_REFILL_ASSEMBLER -- requirements
Module: cva6_icache_refill_assembler

Interface
REQ-001 SHALL have parameter AxiDataWidth, default 64, width of one memory read-response beat in bits (multiple of 64).
REQ-002 SHALL have parameter IcacheLineWidth, default 128, I$ line width in bits (multiple of AxiDataWidth, >= AxiDataWidth).
REQ-003 SHALL have parameter TidWidth, default 4, transaction-ID width.
REQ-004 SHALL derive NBEATS = IcacheLineWidth/AxiDataWidth and WIDX = max(1, log2(AxiDataWidth/64)).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  1  I$ miss request issued toward the memory arbiter.
REQ-008 req_ready_o  out  1  block can track a new miss.
REQ-009 req_nc_i  in  1  miss is uncacheable.
REQ-010 req_word_idx_i  in  WIDX  paddr[3 +: WIDX] of the miss.
REQ-011 req_tid_i  in  TidWidth  miss transaction ID.
REQ-012 mem_resp_valid_i  in  1  read beat from the arbiter's I$ response port.
REQ-013 mem_resp_ready_o  out  1  beat accepted.
REQ-014 mem_resp_data_i  in  AxiDataWidth  beat data.
REQ-015 mem_resp_id_i  in  TidWidth  beat ID.
REQ-016 mem_resp_last_i  in  1  final beat of the burst.
REQ-017 mem_resp_error_i  in  1  beat carries a bus error.
REQ-018 rtrn_valid_o  out  1  one-cycle refill-complete pulse to the I$ (no ready; the I$ always accepts).
REQ-019 rtrn_data_o  out  IcacheLineWidth  assembled line.
REQ-020 rtrn_tid_o  out  TidWidth  ID of the completed miss.
REQ-021 rtrn_err_o  out  1  refill error; qualified by rtrn_valid_o.

Function
REQ-022 SHALL implement FSM states IDLE, FILL, DONE; exactly one miss is tracked at a time.
REQ-023 IDLE: req_ready_o=1, mem_resp_ready_o=0; on req_valid_i, capture nc, word_idx and tid, clear line buffer to zero, beat counter to 0, err to 0, and go to FILL.
REQ-024 FILL: req_ready_o=0, mem_resp_ready_o=1; each accepted beat (valid&ready) is one transfer.
REQ-025 Cacheable beat SHALL be written to buffer bits [cnt*AxiDataWidth +: AxiDataWidth], then cnt increments, saturating at NBEATS-1.
REQ-026 Uncacheable beat SHALL place the 64-bit word data[word_idx*64 +: 64] in buffer bits [63:0], upper bits zero (word_idx forced to 0 when AxiDataWidth=64).
REQ-027 err SHALL be set sticky on any accepted beat with: mem_resp_error_i=1; mem_resp_id_i != captured tid; cacheable beat accepted with cnt already at NBEATS-1 and a previous beat already written there (overflow, data dropped); uncacheable second beat (data dropped).
REQ-028 Beat with mem_resp_last_i=1 SHALL move FILL->DONE; if cacheable and fewer than NBEATS beats received, err SHALL be set and missing slices remain zero.
REQ-029 DONE: rtrn_valid_o=1 for exactly one cycle with buffer, captured tid and err; both ready outputs 0; next state IDLE unconditionally.
REQ-030 Latency: rtrn_valid_o asserts the cycle after the last beat is accepted; a new request can be accepted the cycle after the DONE cycle.
REQ-031 Outside DONE, rtrn_valid_o=0 and rtrn_err_o=0; rtrn_data_o/rtrn_tid_o SHALL hold the registered buffer/tid (no combinational path from mem_resp_* to rtrn_*).
REQ-032 mem_resp_valid_i in IDLE or DONE SHALL not be accepted (ready=0) and SHALL not alter state.
REQ-033 req_valid_i outside IDLE SHALL be ignored (ready=0).

Reset
REQ-034 On rst_ni=0, asynchronously: state=IDLE, cnt=0, err=0, buffer=0, captured tid/nc/word_idx=0; outputs req_ready_o=1, mem_resp_ready_o=0, rtrn_valid_o=0, rtrn_data_o=0, rtrn_tid_o=0, rtrn_err_o=0.
REQ-035 Reset asserted mid-FILL SHALL discard the partial line with no rtrn_valid_o pulse.

Verification
REQ-036 Cacheable, defaults: req tid=3; beats 0x1111..1111 then 0x2222..2222 (last, id 3) -> one cycle later rtrn_valid_o=1, data=0x2222..2222_1111..1111, tid=3, err=0, then IDLE.
REQ-037 Uncacheable, AxiDataWidth=128: word_idx=1, beat data upper=0xAAAA..AAAA, lower=0x5555..5555 (last) -> rtrn_data_o=0x...0000_AAAA..AAAA, err=0.
REQ-038 Early last: cacheable, single beat 0x77..77 with last -> data=0x0..0_77..77, err=1.
REQ-039 Error/ID mismatch: beat 0 error=1, beat 1 id=5 vs tid 3 -> rtrn pulse with err=1; backpressure: responses driven in IDLE see ready=0, no pulse.
REQ-040 Reset after first beat of a burst -> all outputs at reset values, no pulse; a following clean miss completes normally with err=0.

Source files
------------

// File: rtl/cva6_icache_refill_assembler.sv
// Collects AXI read beats of one I$ miss into a full cache line and returns it
// to the I$ as a single-cycle refill pulse with accumulated error status.
module cva6_icache_refill_assembler #(
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned IcacheLineWidth = 128,
    parameter int unsigned TidWidth        = 4,
    localparam int unsigned NBEATS = IcacheLineWidth / AxiDataWidth,
    localparam int unsigned NWORDS = AxiDataWidth / 64,
    localparam int unsigned WIDX   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_nc_i,
    input  logic [WIDX-1:0]            req_word_idx_i,
    input  logic [TidWidth-1:0]        req_tid_i,
    input  logic                       mem_resp_valid_i,
    output logic                       mem_resp_ready_o,
    input  logic [AxiDataWidth-1:0]    mem_resp_data_i,
    input  logic [TidWidth-1:0]        mem_resp_id_i,
    input  logic                       mem_resp_last_i,
    input  logic                       mem_resp_error_i,
    output logic                       rtrn_valid_o,
    output logic [IcacheLineWidth-1:0] rtrn_data_o,
    output logic [TidWidth-1:0]        rtrn_tid_o,
    output logic                       rtrn_err_o
);

    localparam int unsigned CNTW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e                     state_q;
    logic [IcacheLineWidth-1:0] line_q, line_d;
    logic [CNTW-1:0]            cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       top_full_q, top_full_d;
    logic                       seen_q, seen_d;
    logic                       nc_q;
    logic [WIDX-1:0]            widx_q;
    logic [TidWidth-1:0]        tid_q;
    logic                       req_ready_q, mem_ready_q, rtrn_valid_q, rtrn_err_q;
    logic                       beat_acc;
    logic [WIDX-1:0]            word_sel;
    logic [63:0]                nc_word;

    assign beat_acc = (state_q == FILL) && mem_resp_valid_i && mem_ready_q;

    // With a single 64-bit word per beat the word index carries no information.
    assign word_sel = (NWORDS == 1) ? '0 : widx_q;

    always_comb begin
        nc_word = '0;
        for (int w = 0; w < int'(NWORDS); w++) begin
            if (WIDX'(w) == word_sel) nc_word = mem_resp_data_i[w*64 +: 64];
        end
    end

    // Effect of the beat presented this cycle on the line buffer and status.
    always_comb begin
        line_d     = line_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        top_full_d = top_full_q;
        seen_d     = seen_q;
        if (beat_acc) begin
            seen_d = 1'b1;
            if (mem_resp_error_i || (mem_resp_id_i != tid_q)) err_d = 1'b1;
            if (nc_q) begin
                if (seen_q) err_d = 1'b1;
                else        line_d = IcacheLineWidth'(nc_word);
            end else if (top_full_q) begin
                err_d = 1'b1;
            end else begin
                for (int b = 0; b < int'(NBEATS); b++) begin
                    if (cnt_q == CNTW'(b)) line_d[b*AxiDataWidth +: AxiDataWidth] = mem_resp_data_i;
                end
                if (cnt_q == CNT_MAX) top_full_d = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            // A last beat before the top slot is reached leaves the line short.
            if (mem_resp_last_i && !nc_q && (cnt_q != CNT_MAX)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            line_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            top_full_q   <= 1'b0;
            seen_q       <= 1'b0;
            nc_q         <= 1'b0;
            widx_q       <= '0;
            tid_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_ready_q  <= 1'b0;
            rtrn_valid_q <= 1'b0;
            rtrn_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q     <= FILL;
                        nc_q        <= req_nc_i;
                        widx_q      <= req_word_idx_i;
                        tid_q       <= req_tid_i;
                        line_q      <= '0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        top_full_q  <= 1'b0;
                        seen_q      <= 1'b0;
                        req_ready_q <= 1'b0;
                        mem_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    line_q     <= line_d;
                    cnt_q      <= cnt_d;
                    err_q      <= err_d;
                    top_full_q <= top_full_d;
                    seen_q     <= seen_d;
                    if (beat_acc && mem_resp_last_i) begin
                        state_q      <= DONE;
                        mem_ready_q  <= 1'b0;
                        rtrn_valid_q <= 1'b1;
                        rtrn_err_q   <= err_d;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    rtrn_valid_q <= 1'b0;
                    rtrn_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    mem_ready_q  <= 1'b0;
                    rtrn_valid_q <= 1'b0;
                    rtrn_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o      = req_ready_q;
    assign mem_resp_ready_o = mem_ready_q;
    assign rtrn_valid_o     = rtrn_valid_q;
    assign rtrn_err_o       = rtrn_err_q;
    assign rtrn_data_o      = line_q;
    assign rtrn_tid_o       = tid_q;

endmodule

// File: tb/tb_cva6_icache_refill_assembler.sv
// Self-checking bench: table of miss/beat vectors with a refill scoreboard on the
// default configuration, plus hand sequences on a 128-bit-beat instance.
module tb_cva6_icache_refill_assembler;

    typedef struct packed {
        logic              nc;
        logic              wi;
        logic [3:0]        tid;
        logic [1:0]        nb;
        logic [2:0][63:0]  d;
        logic [2:0][3:0]   id;
        logic [2:0]        e;
        logic [127:0]      exp_line;
        logic              exp_err;
    } vec_t;

    typedef struct packed {
        logic [127:0] line;
        logic [3:0]   tid;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 0, req_nc = 0, req_word_idx = 0;
    logic [3:0]    req_tid = 0;
    logic          mem_valid = 0, mem_last = 0, mem_err = 0;
    logic [63:0]   mem_data = 0;
    logic [3:0]    mem_id = 0;
    logic          req_ready_o, mem_resp_ready_o, rtrn_valid_o, rtrn_err_o;
    logic [127:0]  rtrn_data_o;
    logic [3:0]    rtrn_tid_o;

    logic          w_req_valid = 0, w_req_nc = 0, w_req_word_idx = 0;
    logic [3:0]    w_req_tid = 0;
    logic          w_mem_valid = 0, w_mem_last = 0, w_mem_err = 0;
    logic [127:0]  w_mem_data = 0;
    logic [3:0]    w_mem_id = 0;
    logic          w_req_ready, w_mem_ready, w_rtrn_valid, w_rtrn_err;
    logic [255:0]  w_rtrn_data;
    logic [3:0]    w_rtrn_tid;

    cva6_icache_refill_assembler u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_nc_i(req_nc),
        .req_word_idx_i(req_word_idx), .req_tid_i(req_tid),
        .mem_resp_valid_i(mem_valid), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_data_i(mem_data), .mem_resp_id_i(mem_id),
        .mem_resp_last_i(mem_last), .mem_resp_error_i(mem_err),
        .rtrn_valid_o(rtrn_valid_o), .rtrn_data_o(rtrn_data_o),
        .rtrn_tid_o(rtrn_tid_o), .rtrn_err_o(rtrn_err_o)
    );

    cva6_icache_refill_assembler #(.AxiDataWidth(128), .IcacheLineWidth(256), .TidWidth(4)) u_dut_w (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(w_req_valid), .req_ready_o(w_req_ready), .req_nc_i(w_req_nc),
        .req_word_idx_i(w_req_word_idx), .req_tid_i(w_req_tid),
        .mem_resp_valid_i(w_mem_valid), .mem_resp_ready_o(w_mem_ready),
        .mem_resp_data_i(w_mem_data), .mem_resp_id_i(w_mem_id),
        .mem_resp_last_i(w_mem_last), .mem_resp_error_i(w_mem_err),
        .rtrn_valid_o(w_rtrn_valid), .rtrn_data_o(w_rtrn_data),
        .rtrn_tid_o(w_rtrn_tid), .rtrn_err_o(w_rtrn_err)
    );

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   pushed = 0;
    int   w_pulses = 0;
    exp_t sb[$];
    vec_t vecs[7];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic nc, input logic wi, input logic [3:0] tid, input logic [1:0] nb,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [11:0] ids, input logic [2:0] e,
                                input logic [127:0] xl, input logic xe);
        vec_t v;
        v.nc = nc; v.wi = wi; v.tid = tid; v.nb = nb;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.id = ids; v.e = e; v.exp_line = xl; v.exp_err = xe;
        return v;
    endfunction

    // Scoreboard: every refill pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rtrn_valid_o) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 256'(rtrn_valid_o), 256'(0));
            end else begin
                exp_t ex;
                ex = sb.pop_front();
                check("rtrn_data", 256'(rtrn_data_o), 256'(ex.line));
                check("rtrn_tid", 256'(rtrn_tid_o), 256'(ex.tid));
                check("rtrn_err", 256'(rtrn_err_o), 256'(ex.err));
            end
        end else begin
            check("err_unqualified", 256'(rtrn_err_o), 256'(0));
        end
        if (rst_n && w_rtrn_valid) w_pulses++;
    end

    task automatic run_vec(input vec_t v, input bit hold_req);
        int   n;
        exp_t ex;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("req_ready", 256'(req_ready_o), 256'(1));
        req_valid = 1'b1; req_nc = v.nc; req_word_idx = v.wi; req_tid = v.tid;
        ex.line = v.exp_line; ex.tid = v.tid; ex.err = v.exp_err;
        sb.push_back(ex);
        pushed++;
        @(negedge clk);
        req_valid = hold_req;
        if (hold_req) req_tid = 4'hA;
        for (int b = 0; b < int'(v.nb); b++) begin
            check("mem_ready_fill", 256'(mem_resp_ready_o), 256'(1));
            mem_valid = 1'b1; mem_data = v.d[b]; mem_id = v.id[b]; mem_err = v.e[b];
            mem_last = (b == int'(v.nb) - 1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_valid = 1'b0; mem_last = 1'b0; mem_err = 1'b0;
        check("rtrn_latency", 256'(rtrn_valid_o), 256'(1));
        check("mem_ready_done", 256'(mem_resp_ready_o), 256'(0));
        @(negedge clk);
        check("ready_after_done", 256'(req_ready_o), 256'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 256'(req_ready_o), 256'(1));
        check({tag, "_mem_ready"}, 256'(mem_resp_ready_o), 256'(0));
        check({tag, "_rtrn_valid"}, 256'(rtrn_valid_o), 256'(0));
        check({tag, "_rtrn_data"}, 256'(rtrn_data_o), 256'(0));
        check({tag, "_rtrn_tid"}, 256'(rtrn_tid_o), 256'(0));
        check({tag, "_rtrn_err"}, 256'(rtrn_err_o), 256'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(0, 0, 4'd3, 2'd2, {16{4'h1}}, {16{4'h2}}, 64'h0, 12'h333, 3'b000,
                     {{16{4'h2}}, {16{4'h1}}}, 1'b0);
        vecs[1] = mk(0, 0, 4'd3, 2'd1, {16{4'h7}}, 64'h0, 64'h0, 12'h333, 3'b000,
                     {64'h0, {16{4'h7}}}, 1'b1);
        vecs[2] = mk(0, 0, 4'd3, 2'd2, {8{8'hA5}}, {8{8'h5A}}, 64'h0, 12'h353, 3'b001,
                     {{8{8'h5A}}, {8{8'hA5}}}, 1'b1);
        vecs[3] = mk(1, 1, 4'd9, 2'd1, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 12'h999, 3'b000,
                     {64'h0, 64'hDEAD_BEEF_0123_4567}, 1'b0);
        vecs[4] = mk(1, 0, 4'd4, 2'd2, {4{16'hCAFE}}, {4{16'hBEEF}}, 64'h0, 12'h444, 3'b000,
                     {64'h0, {4{16'hCAFE}}}, 1'b1);
        vecs[5] = mk(0, 0, 4'd6, 2'd3, {8{8'h01}}, {8{8'h02}}, {8{8'h03}}, 12'h666, 3'b000,
                     {{8{8'h02}}, {8{8'h01}}}, 1'b1);
        vecs[6] = mk(0, 0, 4'hF, 2'd2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0,
                     12'hFFF, 3'b000, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 1'b0);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Responses while idle must be refused and leave no trace.
        mem_valid = 1'b1; mem_last = 1'b1; mem_data = {16{4'h9}}; mem_id = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_backpressure", 256'(mem_resp_ready_o), 256'(0));
        end
        mem_valid = 1'b0; mem_last = 1'b0;
        check("idle_data_untouched", 256'(rtrn_data_o), 256'(0));

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i == 6);

        // Reset after the first beat of a burst drops the partial line.
        req_valid = 1'b1; req_nc = 1'b0; req_tid = 4'd3;
        @(negedge clk);
        req_valid = 1'b0;
        mem_valid = 1'b1; mem_data = {16{4'h1}}; mem_id = 4'd3; mem_last = 1'b0;
        @(negedge clk);
        mem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midfill_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_pulse", 256'(rtrn_valid_o), 256'(0));
        run_vec(vecs[0], 1'b0);

        // Uncacheable selection of a 64-bit word from a 128-bit beat.
        for (int wi = 0; wi < 2; wi++) begin
            int n;
            n = 0;
            while (w_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            check("w_req_ready", 256'(w_req_ready), 256'(1));
            w_req_valid = 1'b1; w_req_nc = 1'b1; w_req_word_idx = wi[0]; w_req_tid = 4'd2;
            @(negedge clk);
            w_req_valid = 1'b0;
            w_mem_valid = 1'b1; w_mem_data = {{16{4'hA}}, {16{4'h5}}}; w_mem_id = 4'd2; w_mem_last = 1'b1;
            @(negedge clk);
            w_mem_valid = 1'b0; w_mem_last = 1'b0;
            check("w_rtrn_valid", 256'(w_rtrn_valid), 256'(1));
            check("w_rtrn_data", w_rtrn_data, (wi == 1) ? 256'({16{4'hA}}) : 256'({16{4'h5}}));
            check("w_rtrn_tid", 256'(w_rtrn_tid), 256'(2));
            check("w_rtrn_err", 256'(w_rtrn_err), 256'(0));
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("pulse_count", 256'(pulses), 256'(pushed));
        check("sb_empty", 256'(sb.size()), 256'(0));
        check("w_pulse_count", 256'(w_pulses), 256'(2));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
